// File: rtl/mte_pkg.sv
// Shared types and helpers for the multi-threshold event generator.
package mte_pkg;

  // Trip direction of a threshold unit.
  typedef enum logic {
    POL_RISE = 1'b0,
    POL_FALL = 1'b1
  } pol_e;

  // Compare width: two guard bits keep thresh +/- hyst from overflowing.
  function automatic int unsigned cmp_w(input int unsigned dw);
    return dw + 2;
  endfunction

  // a + b clamped to 2^w - 1 (w < 32).
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] s;
    logic [32:0] m;
    s = {1'b0, a} + {1'b0, b};
    m = (33'd1 << w) - 33'd1;
    return (s > m) ? m[31:0] : s[31:0];
  endfunction

endpackage

// File: rtl/mte_unit.sv
// One threshold unit: lane-serial armed/holdoff recurrence (S2) and
// output mask register plus saturating event counter (S3).
module mte_unit
  import mte_pkg::*;
#(
  parameter int NUM_CHANNELS = 16,
  parameter int DATA_WIDTH   = 20,
  parameter int HOLDOFF_W    = 8,
  parameter int CNT_W        = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_valid1,
  input  logic                               i_valid2,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] i_diff,
  input  logic [DATA_WIDTH-1:0]              i_thresh,
  input  logic [DATA_WIDTH-1:0]              i_hyst,
  input  logic                               i_pol,
  input  logic [HOLDOFF_W-1:0]               i_holdoff,
  input  logic                               i_cnt_clr,
  output logic [NUM_CHANNELS-1:0]            o_mask,
  output logic [CNT_W-1:0]                   o_count
);

  localparam int CW = int'(cmp_w(DATA_WIDTH));
  localparam int PW = $clog2(NUM_CHANNELS + 1);

  logic                    w_fall;
  logic signed [CW-1:0]    w_thr;
  logic signed [CW-1:0]    w_hyst;
  logic signed [CW-1:0]    w_lvl;
  logic [NUM_CHANNELS-1:0] w_trip;
  logic [NUM_CHANNELS-1:0] w_rearm;

  logic                    r_armed;
  logic [HOLDOFF_W-1:0]    r_hold;
  logic [NUM_CHANNELS-1:0] r_mask2;
  logic [NUM_CHANNELS-1:0] r_mask3;
  logic [CNT_W-1:0]        r_cnt;

  logic                    w_armed_nxt;
  logic [HOLDOFF_W-1:0]    w_hold_nxt;
  logic [NUM_CHANNELS-1:0] w_mask_nxt;
  logic [PW-1:0]           w_pop;
  logic [31:0]             w_sum;
  logic                    w_unused_sum;

  assign w_fall = (i_pol == POL_FALL);
  assign w_thr  = {{2{i_thresh[DATA_WIDTH-1]}}, i_thresh};
  assign w_hyst = {2'b00, i_hyst};
  assign w_lvl  = w_fall ? (w_thr + w_hyst) : (w_thr - w_hyst);

  // Per-lane trip/rearm compares are independent of state and run in parallel.
  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_lane
    logic signed [CW-1:0] w_s;
    assign w_s        = {{2{i_diff[k*DATA_WIDTH+DATA_WIDTH-1]}}, i_diff[k*DATA_WIDTH +: DATA_WIDTH]};
    assign w_trip[k]  = w_fall ? (w_s <= w_thr) : (w_s >= w_thr);
    assign w_rearm[k] = w_fall ? (w_s > w_lvl) : (w_s < w_lvl);
  end

  // Serial armed/holdoff recurrence, earliest lane first.
  always_comb begin
    w_armed_nxt = r_armed;
    w_hold_nxt  = r_hold;
    w_mask_nxt  = '0;
    for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
      if (w_hold_nxt != '0) begin
        w_hold_nxt = w_hold_nxt - HOLDOFF_W'(1);
        if (!w_armed_nxt && w_rearm[k]) w_armed_nxt = 1'b1;
      end else if (w_armed_nxt && w_trip[k]) begin
        w_mask_nxt[k] = 1'b1;
        w_armed_nxt   = 1'b0;
        w_hold_nxt    = i_holdoff;
      end else if (!w_armed_nxt && w_rearm[k]) begin
        w_armed_nxt = 1'b1;
      end
    end
  end

  // S2 state: advances only on valid blocks so gaps preserve continuity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b0;
      r_hold  <= '0;
      r_mask2 <= '0;
    end else if (i_valid1) begin
      r_armed <= w_armed_nxt;
      r_hold  <= w_hold_nxt;
      r_mask2 <= w_mask_nxt;
    end
  end

  // Popcount of the S2 mask feeding the counter.
  always_comb begin
    w_pop = '0;
    for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
      w_pop = w_pop + PW'(r_mask2[k]);
    end
  end

  assign w_sum        = sat_add(32'(r_cnt), 32'(w_pop), CNT_W);
  assign w_unused_sum = ^w_sum[31:CNT_W];

  // S3: mask output register and counter; clear beats same-cycle events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask3 <= '0;
      r_cnt   <= '0;
    end else begin
      if (i_valid2) r_mask3 <= r_mask2;
      if (i_cnt_clr) r_cnt <= '0;
      else if (i_valid2) r_cnt <= w_sum[CNT_W-1:0];
    end
  end

  assign o_mask  = r_mask3;
  assign o_count = r_cnt;

endmodule

// File: rtl/multi_thresh_event_gen.sv
// Multi-threshold crossing event generator: S1 input/config register,
// NUM_THRESH lane-serial threshold units, 3-clock valid pipeline.
module multi_thresh_event_gen
  import mte_pkg::*;
#(
  parameter int NUM_CHANNELS = 16,
  parameter int DATA_WIDTH   = 20,
  parameter int NUM_THRESH   = 2,
  parameter int HOLDOFF_W    = 8,
  parameter int CNT_W        = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               valid_in,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] diff_in,
  input  logic [NUM_THRESH*DATA_WIDTH-1:0]   thresh,
  input  logic [NUM_THRESH*DATA_WIDTH-1:0]   hyst,
  input  logic [NUM_THRESH-1:0]              polarity,
  input  logic [HOLDOFF_W-1:0]               holdoff,
  input  logic                               cnt_clr,
  output logic [NUM_THRESH*NUM_CHANNELS-1:0] event_mask,
  output logic [NUM_THRESH*CNT_W-1:0]        event_count,
  output logic                               valid_out
);

  logic                               r_valid1;
  logic                               r_valid2;
  logic                               r_valid3;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] r_diff1;
  logic [NUM_THRESH*DATA_WIDTH-1:0]   r_thresh1;
  logic [NUM_THRESH*DATA_WIDTH-1:0]   r_hyst1;
  logic [NUM_THRESH-1:0]              r_pol1;
  logic [HOLDOFF_W-1:0]               r_holdoff1;

  logic [NUM_CHANNELS-1:0] w_mask [NUM_THRESH];
  logic [CNT_W-1:0]        w_cnt  [NUM_THRESH];

  // S1: capture the block together with its configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_diff1    <= '0;
      r_thresh1  <= '0;
      r_hyst1    <= '0;
      r_pol1     <= '0;
      r_holdoff1 <= '0;
    end else if (valid_in) begin
      r_diff1    <= diff_in;
      r_thresh1  <= thresh;
      r_hyst1    <= hyst;
      r_pol1     <= polarity;
      r_holdoff1 <= holdoff;
    end
  end

  // Valid pipeline S1 -> S2 -> S3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid1 <= 1'b0;
      r_valid2 <= 1'b0;
      r_valid3 <= 1'b0;
    end else begin
      r_valid1 <= valid_in;
      r_valid2 <= r_valid1;
      r_valid3 <= r_valid2;
    end
  end

  for (genvar t = 0; t < NUM_THRESH; t++) begin : g_unit
    mte_unit #(
      .NUM_CHANNELS (NUM_CHANNELS),
      .DATA_WIDTH   (DATA_WIDTH),
      .HOLDOFF_W    (HOLDOFF_W),
      .CNT_W        (CNT_W)
    ) u_unit (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_valid1  (r_valid1),
      .i_valid2  (r_valid2),
      .i_diff    (r_diff1),
      .i_thresh  (r_thresh1[t*DATA_WIDTH +: DATA_WIDTH]),
      .i_hyst    (r_hyst1[t*DATA_WIDTH +: DATA_WIDTH]),
      .i_pol     (r_pol1[t]),
      .i_holdoff (r_holdoff1),
      .i_cnt_clr (cnt_clr),
      .o_mask    (w_mask[t]),
      .o_count   (w_cnt[t])
    );
  end

  // Pack per-unit results into the flat output buses.
  always_comb begin
    event_mask  = '0;
    event_count = '0;
    for (int unsigned t = 0; t < NUM_THRESH; t++) begin
      event_mask[t*NUM_CHANNELS +: NUM_CHANNELS] = w_mask[t];
      event_count[t*CNT_W +: CNT_W]              = w_cnt[t];
    end
  end

  assign valid_out = r_valid3;

endmodule

// File: tb/tb_multi_thresh_event_gen.sv
// Directed table-driven bench for multi_thresh_event_gen (16 lanes, 2 units, CNT_W=4).
module tb_multi_thresh_event_gen;

  localparam int NC = 16;
  localparam int DW = 20;
  localparam int NT = 2;
  localparam int HW = 8;
  localparam int CW = 4;
  localparam int NROWS = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              valid_in;
  logic [NC*DW-1:0]  diff_in;
  logic [NT*DW-1:0]  thresh;
  logic [NT*DW-1:0]  hyst;
  logic [NT-1:0]     polarity;
  logic [HW-1:0]     holdoff;
  logic              cnt_clr;
  logic [NT*NC-1:0]  event_mask;
  logic [NT*CW-1:0]  event_count;
  logic              valid_out;

  always #5 clk = ~clk;

  multi_thresh_event_gen #(
    .NUM_CHANNELS (NC),
    .DATA_WIDTH   (DW),
    .NUM_THRESH   (NT),
    .HOLDOFF_W    (HW),
    .CNT_W        (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_in    (valid_in),
    .diff_in     (diff_in),
    .thresh      (thresh),
    .hyst        (hyst),
    .polarity    (polarity),
    .holdoff     (holdoff),
    .cnt_clr     (cnt_clr),
    .event_mask  (event_mask),
    .event_count (event_count),
    .valid_out   (valid_out)
  );

  // Block: lanes in hm take hv, others lv, lane xl overridden with xv.
  typedef struct {
    bit          v;
    int          lv;
    int          hv;
    logic [15:0] hm;
    int          xl;
    int          xv;
    int          t0;
    int          h0;
    bit          p0;
    int          t1;
    int          h1;
    bit          p1;
    int          ho;
    logic [15:0] m0;
    logic [15:0] m1;
  } vec_t;

  vec_t        tbl [NROWS];
  vec_t        e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          c0 = 0;
  int          c1 = 0;
  logic [31:0] held = '0;

  // Unit 0 rising at 100, unit 1 falling at -50 with hyst 10, no holdoff.
  function automatic vec_t blk(input bit v, input int lv, input int hv, input logic [15:0] hm);
    vec_t r;
    r.v = v;  r.lv = lv; r.hv = hv; r.hm = hm; r.xl = -1; r.xv = 0;
    r.t0 = 100; r.h0 = 0;  r.p0 = 1'b0;
    r.t1 = -50; r.h1 = 10; r.p1 = 1'b1;
    r.ho = 0;   r.m0 = '0; r.m1 = '0;
    return r;
  endfunction

  function automatic int sat15(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t r, input bit clr);
    @(negedge clk);
    valid_in = r.v;
    cnt_clr  = clr;
    for (int k = 0; k < NC; k++) begin
      int s;
      s = r.hm[k] ? r.hv : r.lv;
      if (k == r.xl) s = r.xv;
      diff_in[k*DW +: DW] = DW'(s);
    end
    thresh   = {DW'(r.t1), DW'(r.t0)};
    hyst     = {DW'(r.h1), DW'(r.h0)};
    polarity = {r.p1, r.p0};
    holdoff  = HW'(r.ho);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; cnt_clr = 1'b0;
    diff_in = '0; thresh = '0; hyst = '0; polarity = '0; holdoff = '0;

    // Rising/first-crossing
    tbl[0]  = blk(1, 0, 0, 16'h0000);
    tbl[1]  = blk(1, 0, 100, 16'h0020);   tbl[1].m0 = 16'h0020;
    // Hysteresis 20 on unit 0: 110, dip 90, 110 -> one event; dip 79, 100 -> second
    tbl[2]  = blk(1, 90, 110, 16'h0404);  tbl[2].h0 = 20; tbl[2].m0 = 16'h0004;
    tbl[3]  = blk(1, 90, 100, 16'h0100);  tbl[3].h0 = 20; tbl[3].xl = 4; tbl[3].xv = 79;
    tbl[3].m0 = 16'h0100;
    // Falling unit 1: -45 does not re-arm, -35 does
    tbl[4]  = blk(1, -45, -60, 16'h0208); tbl[4].h0 = 20; tbl[4].m1 = 16'h0008;
    tbl[5]  = blk(1, -45, -60, 16'h0080); tbl[5].h0 = 20; tbl[5].xl = 2; tbl[5].xv = -35;
    tbl[5].m1 = 16'h0080;
    // Holdoff 20: event lane 14, suppressed at samples 4 and 20, fires at 21
    tbl[6]  = blk(1, 0, 100, 16'h4000);   tbl[6].ho = 20; tbl[6].m0 = 16'h4000;
    tbl[7]  = blk(1, 0, 100, 16'h0004);   tbl[7].ho = 20;
    tbl[8]  = blk(1, 0, 100, 16'h000C);   tbl[8].ho = 20; tbl[8].m0 = 16'h0008;
    // Residual holdoff of 8 drains, then event lane 10; then 3-slot gap
    tbl[9]  = blk(1, 0, 100, 16'h0400);   tbl[9].m0 = 16'h0400;
    tbl[10] = blk(0, 0, 100, 16'h0001);
    tbl[11] = blk(0, 0, 100, 16'h0001);
    tbl[12] = blk(0, 0, 100, 16'h0001);
    tbl[13] = blk(1, 0, 100, 16'h0001);   tbl[13].m0 = 16'h0001;
    // Eight events per block push the 4-bit counter into saturation
    tbl[14] = blk(1, 0, 100, 16'hAAAA);   tbl[14].m0 = 16'hAAAA;
    tbl[15] = blk(1, 0, 100, 16'hAAAA);   tbl[15].m0 = 16'hAAAA;

    repeat (3) @(negedge clk);
    chk("reset valid_out", 64'(valid_out), 64'd0);
    chk("reset mask", 64'(event_mask), 64'd0);
    chk("reset count", 64'(event_count), 64'd0);
    rst_n = 1'b1;

    for (int j = 0; j < NROWS + 2; j++) begin
      if (j < NROWS) apply(tbl[j], 1'b0);
      else           apply(blk(0, 0, 0, 16'h0000), 1'b0);
      if (j >= 2) begin
        e = tbl[j-2];
        if (e.v) begin
          held = {e.m1, e.m0};
          c0   = sat15(c0 + $countones(e.m0));
          c1   = sat15(c1 + $countones(e.m1));
        end
        chk($sformatf("row%0d valid_out", j-2), 64'(valid_out), 64'(e.v));
        chk($sformatf("row%0d mask", j-2), 64'(event_mask), 64'(held));
        chk($sformatf("row%0d count0", j-2), 64'(event_count[3:0]), 64'(c0));
        chk($sformatf("row%0d count1", j-2), 64'(event_count[7:4]), 64'(c1));
      end
    end

    // cnt_clr on the same edge the event lands: counter reads 0
    apply(blk(1, 0, 100, 16'h0008), 1'b0);
    apply(blk(0, 0, 0, 16'h0000), 1'b0);
    apply(blk(0, 0, 0, 16'h0000), 1'b1);
    chk("clr valid_out", 64'(valid_out), 64'd1);
    chk("clr mask", 64'(event_mask), 64'h8);
    chk("clr count0", 64'(event_count[3:0]), 64'd0);
    chk("clr count1", 64'(event_count[7:4]), 64'd0);
    apply(blk(0, 0, 0, 16'h0000), 1'b0);
    chk("after clr valid_out", 64'(valid_out), 64'd0);
    chk("after clr mask held", 64'(event_mask), 64'h8);
    chk("after clr count0", 64'(event_count[3:0]), 64'd0);

    // Mid-stream reset with a block in flight
    apply(blk(1, 0, 100, 16'h0020), 1'b0);
    apply(blk(0, 0, 0, 16'h0000), 1'b0);
    apply(blk(0, 0, 0, 16'h0000), 1'b0);
    chk("pre-rst mask", 64'(event_mask), 64'h20);
    chk("pre-rst count0", 64'(event_count[3:0]), 64'd1);
    apply(blk(1, 0, 100, 16'h0020), 1'b0);
    apply(blk(0, 0, 0, 16'h0000), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst valid_out", 64'(valid_out), 64'd0);
    chk("rst mask", 64'(event_mask), 64'd0);
    chk("rst count", 64'(event_count), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    apply(blk(0, 0, 0, 16'h0000), 1'b0);
    chk("flush valid_out 1", 64'(valid_out), 64'd0);
    apply(blk(0, 0, 0, 16'h0000), 1'b0);
    chk("flush valid_out 2", 64'(valid_out), 64'd0);
    // Armed cleared: an all-100 block cannot trip before a sub-threshold sample
    apply(blk(1, 100, 100, 16'hFFFF), 1'b0);
    chk("lat edge1 valid_out", 64'(valid_out), 64'd0);
    apply(blk(1, 0, 100, 16'h0020), 1'b0);
    chk("lat edge2 valid_out", 64'(valid_out), 64'd0);
    apply(blk(0, 0, 0, 16'h0000), 1'b0);
    chk("lat edge3 valid_out", 64'(valid_out), 64'd1);
    chk("disarmed mask", 64'(event_mask), 64'd0);
    chk("disarmed count0", 64'(event_count[3:0]), 64'd0);
    apply(blk(0, 0, 0, 16'h0000), 1'b0);
    chk("post-rst valid_out", 64'(valid_out), 64'd1);
    chk("post-rst mask", 64'(event_mask), 64'h20);
    chk("post-rst count0", 64'(event_count[3:0]), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
